// File: rtl/alarm_siren_ctrl_if.sv
// Bundle of the alarm-level input, the operator acknowledge and the siren/lamp outputs of alarm_siren_ctrl.
// The master drives alarm_in/ack; the slave (the controller) drives the rest and exposes its FSM state.
interface alarm_siren_ctrl_if;
  logic       alarm_in;
  logic       ack;
  logic       siren;
  logic       active;
  logic       silenced;
  logic       strobe;
  logic [7:0] event_count;
  logic [1:0] state_dbg;

  modport master (
    output alarm_in, ack,
    input  siren, active, silenced, strobe, event_count, state_dbg
  );

  modport slave (
    input  alarm_in, ack,
    output siren, active, silenced, strobe, event_count, state_dbg
  );
endinterface

// File: rtl/alarm_siren_ctrl.sv
// Siren controller: gated square-wave tone with on/off cadence, acknowledge, auto-silence and episode counter.
// Optional warning lamp built only when the STROBE_EN macro is defined; otherwise strobe is tied low.
module alarm_siren_ctrl #(
  parameter int TONE_DIV    = 2,
  parameter int CADENCE_ON  = 8,
  parameter int CADENCE_OFF = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  alarm_siren_ctrl_if.slave bus
);

  // Interface semantics: there is no valid/ready pair. alarm_in and ack are levels
  // sampled on every rising clk edge; all outputs are registered and change only on
  // that edge, together with the state they describe.

  localparam int CAD_MAX = (CADENCE_ON > CADENCE_OFF) ? CADENCE_ON : CADENCE_OFF;
  localparam int CAD_W   = $clog2(CAD_MAX + 1);
  localparam int TONE_W  = $clog2(TONE_DIV + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CAD_W-1:0]  CAD_ON_LAST  = CAD_W'(CADENCE_ON - 1);
  localparam logic [CAD_W-1:0]  CAD_OFF_LAST = CAD_W'(CADENCE_OFF - 1);
  localparam logic [TONE_W-1:0] TONE_LAST    = TONE_W'(TONE_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT     = TO_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SOUND_ON  = 2'd1,
    SOUND_OFF = 2'd2,
    SILENCED  = 2'd3
  } state_t;

  state_t            state;
  logic              siren_q;
  logic              active_q;
  logic              silenced_q;
  logic [7:0]        event_count_q;
  logic [CAD_W-1:0]  cad_cnt;
  logic [TONE_W-1:0] tone_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_inc;

  // Count of clocks spent sounding, including the current one.
  assign to_inc = to_cnt + TO_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      siren_q       <= 1'b0;
      active_q      <= 1'b0;
      silenced_q    <= 1'b0;
      event_count_q <= 8'd0;
      cad_cnt       <= '0;
      tone_cnt      <= '0;
      to_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.alarm_in) begin
            state    <= SOUND_ON;
            siren_q  <= 1'b1;
            active_q <= 1'b1;
            cad_cnt  <= '0;
            tone_cnt <= '0;
            to_cnt   <= '0;
            if (event_count_q != 8'hFF) event_count_q <= event_count_q + 8'd1;
          end
        end

        SOUND_ON, SOUND_OFF: begin
          if (!bus.alarm_in) begin
            state    <= IDLE;
            siren_q  <= 1'b0;
            active_q <= 1'b0;
          end else if (bus.ack || (to_inc == TO_LIMIT)) begin
            state      <= SILENCED;
            siren_q    <= 1'b0;
            active_q   <= 1'b0;
            silenced_q <= 1'b1;
          end else begin
            to_cnt <= to_inc;
            if (state == SOUND_ON) begin
              if (cad_cnt == CAD_ON_LAST) begin
                state   <= SOUND_OFF;
                siren_q <= 1'b0;
                cad_cnt <= '0;
              end else begin
                cad_cnt <= cad_cnt + CAD_W'(1);
                if (tone_cnt == TONE_LAST) begin
                  tone_cnt <= '0;
                  siren_q  <= ~siren_q;
                end else begin
                  tone_cnt <= tone_cnt + TONE_W'(1);
                end
              end
            end else begin
              // Each burst restarts the tone in its high phase.
              if (cad_cnt == CAD_OFF_LAST) begin
                state    <= SOUND_ON;
                siren_q  <= 1'b1;
                cad_cnt  <= '0;
                tone_cnt <= '0;
              end else begin
                cad_cnt <= cad_cnt + CAD_W'(1);
              end
            end
          end
        end

        SILENCED: begin
          if (!bus.alarm_in) begin
            state      <= IDLE;
            silenced_q <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          siren_q    <= 1'b0;
          active_q   <= 1'b0;
          silenced_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.siren       = siren_q;
  assign bus.active      = active_q;
  assign bus.silenced    = silenced_q;
  assign bus.event_count = event_count_q;
  assign bus.state_dbg   = state;

`ifdef STROBE_EN
  // The lamp is lit in every non-IDLE state; the next state is non-IDLE exactly when alarm_in is high.
  logic strobe_q;

  always_ff @(posedge clk) begin
    if (rst) strobe_q <= 1'b0;
    else     strobe_q <= bus.alarm_in;
  end

  assign bus.strobe = strobe_q;
`else
  assign bus.strobe = 1'b0;
`endif

endmodule
